qspi_dispatcher: RTL and testbench
==================================

# qspi_dispatcher

Parametrised QSPI-to-encrypter front end: receives nibble-serial (LANES-wide) frames from the QSPI host and either loads a key into all encrypter lanes or splits a data stream into ENC_WIDTH packets dispatched round-robin to NUM_ENC encrypters. Each packet is tagged with a wrapping key-rotation index. It sits between the QSPI receiver and the encrypter array. It adds per-encrypter valid/ready handshakes, host back-pressure, truncated-frame detection and correct index wrap.

## Interface
- NUM_ENC, 4: number of encrypter lanes (≥1).
- LANES, 4: QSPI data width per beat.
- ENC_WIDTH, 64: packet width; multiple of LANES.
- KEY_WIDTH, 128: key width; multiple of LANES.
- ROT_COUNT, 8: key-rotation modulus (≥1). ROT_W = max(1, clog2(ROT_COUNT)).
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- qspi_data  input  LANES  beat data.
- qspi_sending  input  1  frame-active level from host.
- qspi_ready  output  1  block accepts a beat this cycle.
- prog  input  1  arms next frame as a key frame.
- enc_key  output  KEY_WIDTH  broadcast key.
- enc_program  output  NUM_ENC  per-lane key-load request.
- enc_data  output  NUM_ENC*ENC_WIDTH  per-lane packet; lane i at [i*ENC_WIDTH +: ENC_WIDTH].
- enc_rot  output  NUM_ENC*ROT_W  per-lane rotation index.
- enc_valid  output  NUM_ENC  per-lane packet valid.
- enc_ready  input  NUM_ENC  per-lane ready; completes both program and data handshakes.
- key_valid  output  1  a complete key has been loaded since reset.
- frame_done  output  1  one-cycle pulse: frame completed cleanly.
- frame_error  output  1  one-cycle pulse: frame truncated or rejected.

## Operation
- Beat accepted on posedge when qspi_sending && qspi_ready. Beat k fills bits [k*LANES +: LANES] (LSB nibble first).
- Frame start: qspi_sending high with previous-cycle qspi_sending low, in IDLE or KEY_ARM. The start beat is beat 0.
- States:
  - IDLE: qspi_ready=1.
    - prog high → KEY_ARM.
    - Frame start with prog high, or from KEY_ARM → KEY_RX.
    - Frame start otherwise → DATA_RX if key_valid; else frame_error and DROP.
  - KEY_ARM: qspi_ready=1. Waits for frame start.
  - KEY_RX: collects KEY_WIDTH/LANES beats into a shadow register.
    - After the last beat, qspi_ready=0 → KEY_LOAD.
    - qspi_sending low early → frame_error, enc_key unchanged → IDLE.
  - KEY_LOAD: copies shadow to enc_key and sets enc_program to all ones.
    - Each enc_program[i] clears on the cycle after enc_ready[i] is sampled high with it.
    - When all are clear: key_valid=1, frame_done → DROP.
  - DATA_RX: collects ENC_WIDTH/LANES beats. On the last beat → PUSH with qspi_ready=0.
    - qspi_sending low on a packet boundary → frame_done → IDLE.
    - qspi_sending low mid-packet → partial packet discarded, frame_error → IDLE.
  - PUSH: drives lane idx with the packet and rot, and asserts enc_valid[idx]. Holds until enc_ready[idx].
    - On transfer: enc_valid[idx] clears, idx = (idx+1) mod NUM_ENC, rot = (rot+1) mod ROT_COUNT → DATA_RX, qspi_ready=1.
  - DROP: qspi_ready=0 until qspi_sending is low → IDLE. Extra beats are never accepted.
- idx and rot reset to 0 at every data-frame start. Lane outputs hold their last values after a transfer.
- prog outside IDLE/KEY_ARM is ignored.

## Timing
- Reset asserted: every output is 0, and state is IDLE. qspi_ready rises on the first posedge after release.
- Last data beat at edge t: enc_valid[idx] high after t.
  - If enc_ready[idx] is high at t+1, enc_valid is low and qspi_ready is high after t+1.
  - Minimum throughput: one packet per (ENC_WIDTH/LANES + 1) cycles.
- Last key beat at edge t: enc_program all high after t. With all enc_ready high at t+1, enc_program clears and key_valid is high after t+1.
- qspi_sending falls during PUSH: the transfer completes, then frame_done, then IDLE.
- frame_done and frame_error are exclusive, one cycle each.
- Reset mid-operation: all registers clear immediately. key_valid drops to 0.

## Test plan
Parameters for all scenarios: NUM_ENC=4, LANES=4, ENC_WIDTH=16, KEY_WIDTH=32, ROT_COUNT=3.
- Key load: pulse prog, send beats 1..8 with all enc_ready=1 → enc_key=32'h87654321, enc_program all high for 1 cycle, then key_valid=1 and frame_done.
- Data dispatch: key loaded; send 20 beats forming packets 16'h4321, 16'h8765, … → lanes 0,1,2,3,0 receive in order with rot 0,1,2,0,1; frame_done.
- Back-pressure: enc_ready[1]=0 for 5 cycles during packet 1 → enc_valid[1] held and qspi_ready=0 for those 5 cycles; no beat lost; data matches.
- Truncation: drop qspi_sending after 2 beats of a data packet → frame_error, no enc_valid; next frame starts at lane 0, rot 0.
- No key: data frame after reset → frame_error, qspi_ready=0 until qspi_sending falls, no enc_valid.
- Reset during KEY_LOAD → all outputs 0, key_valid=0, enc_key=0.

Source files
------------

// File: rtl/qspi_dispatcher_if.sv
// Bundles every signal between the QSPI receiver/encrypter array and qspi_dispatcher.
// master: the environment side (host beats, prog, encrypter ready).
// slave:  the dispatcher side (qspi_ready, key/packet lanes, frame status pulses).
interface qspi_dispatcher_if #(
    parameter int NUM_ENC   = 4,
    parameter int LANES     = 4,
    parameter int ENC_WIDTH = 64,
    parameter int KEY_WIDTH = 128,
    parameter int ROT_COUNT = 8
);
    localparam int ROT_W = (ROT_COUNT > 1) ? $clog2(ROT_COUNT) : 1;

    logic [LANES-1:0]             qspi_data;
    logic                         qspi_sending;
    logic                         qspi_ready;
    logic                         prog;
    logic [KEY_WIDTH-1:0]         enc_key;
    logic [NUM_ENC-1:0]           enc_program;
    logic [NUM_ENC*ENC_WIDTH-1:0] enc_data;
    logic [NUM_ENC*ROT_W-1:0]     enc_rot;
    logic [NUM_ENC-1:0]           enc_valid;
    logic [NUM_ENC-1:0]           enc_ready;
    logic                         key_valid;
    logic                         frame_done;
    logic                         frame_error;

    modport master (
        output qspi_data, qspi_sending, prog, enc_ready,
        input  qspi_ready, enc_key, enc_program, enc_data, enc_rot, enc_valid,
               key_valid, frame_done, frame_error
    );

    modport slave (
        input  qspi_data, qspi_sending, prog, enc_ready,
        output qspi_ready, enc_key, enc_program, enc_data, enc_rot, enc_valid,
               key_valid, frame_done, frame_error
    );
endinterface

// File: rtl/qspi_dispatcher.sv
// Purpose: assembles nibble-serial QSPI frames into a broadcast key or round-robin packets.
// Latency: key/packet lanes valid the cycle after the last beat; one hand-off cycle per packet.
// Backpressure: qspi_ready drops while a key load or packet push waits on enc_ready.
// Ports: clk, reset (async active-low), bus (qspi_dispatcher_if.slave).
module qspi_dispatcher #(
    parameter int NUM_ENC   = 4,
    parameter int LANES     = 4,
    parameter int ENC_WIDTH = 64,
    parameter int KEY_WIDTH = 128,
    parameter int ROT_COUNT = 8
) (
    input  logic             clk,
    input  logic             reset,
    qspi_dispatcher_if.slave bus
);
    localparam int ROT_W     = (ROT_COUNT > 1) ? $clog2(ROT_COUNT) : 1;
    localparam int IDX_W     = (NUM_ENC > 1) ? $clog2(NUM_ENC) : 1;
    localparam int KEY_BEATS = KEY_WIDTH / LANES;
    localparam int PKT_BEATS = ENC_WIDTH / LANES;
    localparam int MAX_BEATS = (KEY_BEATS > PKT_BEATS) ? KEY_BEATS : PKT_BEATS;
    localparam int CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_KEY_ARM, S_KEY_RX, S_KEY_LOAD, S_DATA_RX, S_PUSH, S_DROP
    } state_t;

    state_t                       state, state_nxt;
    logic [CNT_W-1:0]             beat_cnt, cnt_nxt;
    logic                         sending_q, ready_q;
    logic [KEY_WIDTH-1:0]         key_shadow, key_upd, key_q;
    logic [ENC_WIDTH-1:0]         pkt_shadow, pkt_upd;
    logic [NUM_ENC-1:0]           program_q, valid_q;
    logic [NUM_ENC*ENC_WIDTH-1:0] data_q;
    logic [NUM_ENC*ROT_W-1:0]     rot_out_q;
    logic                         key_valid_q, done_q, error_q;
    logic [IDX_W-1:0]             idx, lane;
    logic [ROT_W-1:0]             rot, lane_rot;

    logic frame_start, key_last, pkt_last;
    logic cap_key, cap_pkt, load_key, push, start_data, xfer, key_ok, done_p, err_p;

    // A frame starts on the rising level of qspi_sending; ready_q gates the one
    // cycle after reset release where IDLE is not yet accepting.
    assign frame_start = bus.qspi_sending && !sending_q && ready_q;
    assign key_last    = (beat_cnt == CNT_W'(KEY_BEATS - 1));
    assign pkt_last    = (beat_cnt == CNT_W'(PKT_BEATS - 1));

    // Shadow registers with the current beat merged in, so the last beat can be
    // forwarded to the lanes on the same edge it is accepted.
    always_comb begin
        key_upd = key_shadow;
        key_upd[int'(beat_cnt)*LANES +: LANES] = bus.qspi_data;
        pkt_upd = pkt_shadow;
        pkt_upd[int'(beat_cnt)*LANES +: LANES] = bus.qspi_data;
    end

    // A single-beat packet can push on the frame-start edge, before idx/rot are cleared.
    assign lane     = start_data ? '0 : idx;
    assign lane_rot = start_data ? '0 : rot;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = beat_cnt;
        cap_key    = 1'b0;
        cap_pkt    = 1'b0;
        load_key   = 1'b0;
        push       = 1'b0;
        start_data = 1'b0;
        xfer       = 1'b0;
        key_ok     = 1'b0;
        done_p     = 1'b0;
        err_p      = 1'b0;
        case (state)
            S_IDLE, S_KEY_ARM: begin
                if (frame_start) begin
                    if (state == S_KEY_ARM || bus.prog) begin
                        cap_key = 1'b1;
                        if (key_last) begin
                            load_key  = 1'b1;
                            state_nxt = S_KEY_LOAD;
                        end else begin
                            cnt_nxt   = beat_cnt + 1'b1;
                            state_nxt = S_KEY_RX;
                        end
                    end else if (key_valid_q) begin
                        start_data = 1'b1;
                        cap_pkt    = 1'b1;
                        if (pkt_last) begin
                            push      = 1'b1;
                            state_nxt = S_PUSH;
                        end else begin
                            cnt_nxt   = beat_cnt + 1'b1;
                            state_nxt = S_DATA_RX;
                        end
                    end else begin
                        err_p     = 1'b1;
                        state_nxt = S_DROP;
                    end
                end else if (state == S_IDLE && bus.prog) begin
                    state_nxt = S_KEY_ARM;
                end
            end
            S_KEY_RX: begin
                if (!bus.qspi_sending) begin
                    err_p     = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else if (ready_q) begin
                    cap_key = 1'b1;
                    if (key_last) begin
                        load_key  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = S_KEY_LOAD;
                    end else begin
                        cnt_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            S_KEY_LOAD: begin
                // Complete once every lane's program request has been acknowledged.
                if ((program_q & ~bus.enc_ready) == '0) begin
                    key_ok    = 1'b1;
                    done_p    = 1'b1;
                    state_nxt = S_DROP;
                end
            end
            S_DATA_RX: begin
                if (!bus.qspi_sending) begin
                    if (beat_cnt == '0) done_p = 1'b1;
                    else                err_p  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else if (ready_q) begin
                    cap_pkt = 1'b1;
                    if (pkt_last) begin
                        push      = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = S_PUSH;
                    end else begin
                        cnt_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            S_PUSH: begin
                if (bus.enc_ready[idx]) begin
                    xfer      = 1'b1;
                    state_nxt = S_DATA_RX;
                end
            end
            S_DROP: begin
                if (!bus.qspi_sending) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sending_q   <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            key_shadow  <= '0;
            key_q       <= '0;
            program_q   <= '0;
            key_valid_q <= 1'b0;
            pkt_shadow  <= '0;
            data_q      <= '0;
            rot_out_q   <= '0;
            valid_q     <= '0;
            idx         <= '0;
            rot         <= '0;
        end else begin
            sending_q <= bus.qspi_sending;
            // Registered so qspi_ready is low in reset and rises on the first edge after.
            ready_q   <= (state_nxt == S_IDLE) || (state_nxt == S_KEY_ARM) ||
                         (state_nxt == S_KEY_RX) || (state_nxt == S_DATA_RX);
            done_q    <= done_p;
            error_q   <= err_p;

            if (cap_key) key_shadow <= key_upd;
            if (load_key) begin
                key_q     <= key_upd;
                program_q <= '1;
            end else if (state == S_KEY_LOAD) begin
                program_q <= program_q & ~bus.enc_ready;
            end
            if (key_ok) key_valid_q <= 1'b1;

            if (cap_pkt) pkt_shadow <= pkt_upd;
            if (start_data) begin
                idx <= '0;
                rot <= '0;
            end
            if (push) begin
                data_q[int'(lane)*ENC_WIDTH +: ENC_WIDTH] <= pkt_upd;
                rot_out_q[int'(lane)*ROT_W +: ROT_W]      <= lane_rot;
                valid_q[lane]                             <= 1'b1;
            end
            if (xfer) begin
                valid_q[idx] <= 1'b0;
                idx <= (idx == IDX_W'(NUM_ENC - 1)) ? '0 : idx + 1'b1;
                rot <= (rot == ROT_W'(ROT_COUNT - 1)) ? '0 : rot + 1'b1;
            end
        end
    end

    assign bus.qspi_ready  = ready_q;
    assign bus.enc_key     = key_q;
    assign bus.enc_program = program_q;
    assign bus.enc_data    = data_q;
    assign bus.enc_rot     = rot_out_q;
    assign bus.enc_valid   = valid_q;
    assign bus.key_valid   = key_valid_q;
    assign bus.frame_done  = done_q;
    assign bus.frame_error = error_q;
endmodule

// File: tb/tb_qspi_dispatcher.sv
// Bench for qspi_dispatcher: directed frames, expected packets/frame events queued
// at stimulus time and retired by an independent negedge monitor.
module tb_qspi_dispatcher;
    localparam int NUM_ENC   = 4;
    localparam int LANES     = 4;
    localparam int ENC_WIDTH = 16;
    localparam int KEY_WIDTH = 32;
    localparam int ROT_COUNT = 3;
    localparam int ROT_W     = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    qspi_dispatcher_if #(.NUM_ENC(NUM_ENC), .LANES(LANES), .ENC_WIDTH(ENC_WIDTH),
                         .KEY_WIDTH(KEY_WIDTH), .ROT_COUNT(ROT_COUNT)) bus ();

    qspi_dispatcher #(.NUM_ENC(NUM_ENC), .LANES(LANES), .ENC_WIDTH(ENC_WIDTH),
                      .KEY_WIDTH(KEY_WIDTH), .ROT_COUNT(ROT_COUNT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int                   lane;
        logic [ENC_WIDTH-1:0] data;
        logic [ROT_W-1:0]     rot;
    } pkt_t;

    localparam logic [1:0] EV_DONE = 2'b10;
    localparam logic [1:0] EV_ERR  = 2'b01;

    pkt_t       pkt_q[$];
    logic [1:0] evt_q[$];
    logic [3:0] beat_buf[0:31];
    int         n_vec = 0;
    int         n_err = 0;
    pkt_t       mon_p;
    logic [1:0] mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_pkt(input int lane, input logic [ENC_WIDTH-1:0] data, input logic [ROT_W-1:0] rot);
        pkt_t p;
        p.lane = lane;
        p.data = data;
        p.rot  = rot;
        pkt_q.push_back(p);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_prog();
        bus.prog = 1'b1;
        @(posedge clk);
        #1;
        bus.prog = 1'b0;
    endtask

    // Drives beat_buf[0..n-1]; each beat is held until an edge where qspi_ready was high.
    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) begin
            int   tmo;
            logic rdy;
            tmo = 0;
            bus.qspi_data    = beat_buf[i];
            bus.qspi_sending = 1'b1;
            do begin
                @(negedge clk);
                rdy = bus.qspi_ready;
                @(posedge clk);
                #1;
                tmo++;
            end while (!rdy && tmo < 300);
            if (!rdy) begin
                n_vec++;
                n_err++;
                $display("FAIL beat_accept_timeout: beat %0d not accepted after %0d cycles", i, tmo);
                break;
            end
        end
        bus.qspi_sending = 1'b0;
        bus.qspi_data    = '0;
    endtask

    // Monitor: retires expected packets on each lane handshake and expected frame events.
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENC; i++) begin
                if (bus.enc_valid[i] && bus.enc_ready[i]) begin
                    if (pkt_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_pkt: lane %0d data 0x%0h, expected no packet",
                                 i, bus.enc_data[i*ENC_WIDTH +: ENC_WIDTH]);
                    end else begin
                        mon_p = pkt_q.pop_front();
                        check("pkt_lane", i, mon_p.lane);
                        check("pkt_data", bus.enc_data[i*ENC_WIDTH +: ENC_WIDTH], mon_p.data);
                        check("pkt_rot", bus.enc_rot[i*ROT_W +: ROT_W], mon_p.rot);
                    end
                end
            end
            if (bus.frame_done || bus.frame_error) begin
                check("done_error_exclusive", bus.frame_done & bus.frame_error, 1'b0);
                if (evt_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_frame_event: done=%0b error=%0b, expected none",
                             bus.frame_done, bus.frame_error);
                end else begin
                    mon_e = evt_q.pop_front();
                    check("frame_event", {bus.frame_done, bus.frame_error}, mon_e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        bus.qspi_data    = '0;
        bus.qspi_sending = 1'b0;
        bus.prog         = 1'b0;
        bus.enc_ready    = '1;
        #3 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_qspi_ready", bus.qspi_ready, 1'b0);
        check("rst_enc_key", bus.enc_key, 32'h0);
        check("rst_enc_program", bus.enc_program, 4'h0);
        check("rst_enc_data", bus.enc_data, 64'h0);
        check("rst_enc_rot", bus.enc_rot, 8'h0);
        check("rst_enc_valid", bus.enc_valid, 4'h0);
        check("rst_key_valid", bus.key_valid, 1'b0);
        check("rst_frame_pulses", {bus.frame_done, bus.frame_error}, 2'b00);
        @(posedge clk);
        #1 reset = 1'b1;
        check("ready_before_first_edge", bus.qspi_ready, 1'b0);
        idle(1);
        check("ready_after_first_edge", bus.qspi_ready, 1'b1);

        // Data frame without a key: rejected, held off until qspi_sending falls
        evt_q.push_back(EV_ERR);
        bus.qspi_data    = 4'h1;
        bus.qspi_sending = 1'b1;
        idle(1);
        repeat (3) begin
            @(negedge clk);
            check("nokey_ready_low", bus.qspi_ready, 1'b0);
        end
        @(posedge clk);
        #1 bus.qspi_sending = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("nokey_ready_restored", bus.qspi_ready, 1'b1);
        check("nokey_key_valid", bus.key_valid, 1'b0);
        idle(4);

        // Key load: beats 1..8
        for (int i = 0; i < 8; i++) beat_buf[i] = 4'(i + 1);
        evt_q.push_back(EV_DONE);
        pulse_prog();
        send_frame(8);
        check("key_program_all", bus.enc_program, 4'hF);
        check("key_value", bus.enc_key, 32'h8765_4321);
        check("key_valid_before_ack", bus.key_valid, 1'b0);
        idle(1);
        check("key_program_cleared", bus.enc_program, 4'h0);
        check("key_valid_after_ack", bus.key_valid, 1'b1);
        idle(5);

        // Data dispatch: 20 beats -> 5 packets, round-robin lanes, rot mod 3
        for (int i = 0; i < 20; i++) beat_buf[i] = 4'(i + 1);
        exp_pkt(0, 16'h4321, 2'd0);
        exp_pkt(1, 16'h8765, 2'd1);
        exp_pkt(2, 16'hCBA9, 2'd2);
        exp_pkt(3, 16'h0FED, 2'd0);
        exp_pkt(0, 16'h4321, 2'd1);
        evt_q.push_back(EV_DONE);
        send_frame(20);
        idle(10);

        // Back-pressure on lane 1 for 5 cycles
        for (int i = 0; i < 12; i++) beat_buf[i] = 4'(15 - i);
        exp_pkt(0, 16'hCDEF, 2'd0);
        exp_pkt(1, 16'h89AB, 2'd1);
        exp_pkt(2, 16'h4567, 2'd2);
        evt_q.push_back(EV_DONE);
        bus.enc_ready[1] = 1'b0;
        fork
            send_frame(12);
            begin
                int t;
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!bus.enc_valid[1] && t < 300);
                if (!bus.enc_valid[1]) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL bp_valid_timeout: enc_valid[1] low after %0d cycles, expected high", t);
                end else begin
                    for (int k = 0; k < 5; k++) begin
                        if (k > 0) @(negedge clk);
                        check("bp_valid_held", bus.enc_valid[1], 1'b1);
                        check("bp_qspi_ready_low", bus.qspi_ready, 1'b0);
                        check("bp_data_held", bus.enc_data[31:16], 16'h89AB);
                    end
                end
                @(posedge clk);
                #1 bus.enc_ready[1] = 1'b1;
            end
        join
        idle(10);

        // Truncation: one full packet plus 2 beats, then a fresh frame restarts at lane 0/rot 0
        for (int i = 0; i < 6; i++) beat_buf[i] = 4'(i + 1);
        exp_pkt(0, 16'h4321, 2'd0);
        evt_q.push_back(EV_ERR);
        send_frame(6);
        idle(6);
        beat_buf[0] = 4'h9;
        beat_buf[1] = 4'hA;
        beat_buf[2] = 4'hB;
        beat_buf[3] = 4'hC;
        exp_pkt(0, 16'hCBA9, 2'd0);
        evt_q.push_back(EV_DONE);
        send_frame(4);
        idle(8);

        // Reset while KEY_LOAD waits for acknowledgement
        bus.enc_ready = '0;
        for (int i = 0; i < 8; i++) beat_buf[i] = 4'(i + 8);
        pulse_prog();
        send_frame(8);
        idle(1);
        check("kl_program_waiting", bus.enc_program, 4'hF);
        check("kl_key_valid_before_rst", bus.key_valid, 1'b1);
        reset = 1'b0;
        #1;
        check("kl_rst_enc_program", bus.enc_program, 4'h0);
        check("kl_rst_enc_key", bus.enc_key, 32'h0);
        check("kl_rst_key_valid", bus.key_valid, 1'b0);
        check("kl_rst_enc_data", bus.enc_data, 64'h0);
        check("kl_rst_enc_rot", bus.enc_rot, 8'h0);
        check("kl_rst_enc_valid", bus.enc_valid, 4'h0);
        check("kl_rst_qspi_ready", bus.qspi_ready, 1'b0);
        bus.enc_ready = '1;
        @(posedge clk);
        #1 reset = 1'b1;
        idle(3);

        check("pkt_queue_drained", pkt_q.size(), 0);
        check("evt_queue_drained", evt_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
